// File: rtl/neuron_driver.sv
// Input-side sequencer for one MAC neuron: reads paired operands from two buffers,
// streams them into the MAC, flushes its output lag and returns the result on valid/ready.
// Optional bias beat is enabled by defining NEURON_DRIVER_BIAS_EN.
module neuron_driver #(
    parameter int WIDTH    = 8,
    parameter int VEC_LEN  = 3,
    parameter int INT_BITS = 2,
    parameter int ADDR_W   = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    output logic                     busy,
    output logic                     rd_en,
    output logic [ADDR_W-1:0]        rd_addr,
    input  logic signed [WIDTH-1:0]  act_rdata,
    input  logic signed [WIDTH-1:0]  wt_rdata,
    output logic                     mac_clear,
    output logic                     mac_enable,
    output logic signed [WIDTH-1:0]  mac_a,
    output logic signed [WIDTH-1:0]  mac_b,
    input  logic signed [WIDTH-1:0]  mac_out,
`ifdef NEURON_DRIVER_BIAS_EN
    input  logic signed [WIDTH-1:0]  bias,
`endif
    output logic signed [WIDTH-1:0]  result,
    output logic                     result_valid,
    input  logic                     result_ready
);

    localparam int FRAC_BITS = WIDTH - INT_BITS;

    // With the bias beat the read stream starts one beat later, so the read index equals the beat.
`ifdef NEURON_DRIVER_BIAS_EN
    localparam int BEATS  = VEC_LEN + 1;
    localparam int RD_OFS = 0;
    localparam logic signed [WIDTH-1:0] ONE = WIDTH'(1 << FRAC_BITS);
`else
    localparam int BEATS  = VEC_LEN;
    localparam int RD_OFS = 1;
`endif

    localparam int CNT_W = $clog2(BEATS + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0] READ_LIMIT = CNT_W'(VEC_LEN);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CLEAR   = 3'd1;
    localparam logic [2:0] S_STREAM  = 3'd2;
    localparam logic [2:0] S_FLUSH   = 3'd3;
    localparam logic [2:0] S_CAPTURE = 3'd4;
    localparam logic [2:0] S_HOLD    = 3'd5;

    if (FRAC_BITS < 1 || VEC_LEN < 1) begin : g_bad_config
        $error("neuron_driver: INT_BITS must be below WIDTH and VEC_LEN at least 1");
    end

    logic [2:0]       state;
    logic [2:0]       state_next;
    logic [CNT_W-1:0] beat;
    logic [CNT_W-1:0] read_idx;

    assign read_idx     = beat + CNT_W'(RD_OFS);
    assign busy         = (state != S_IDLE);
    assign result_valid = (state == S_HOLD);

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (start) state_next = S_CLEAR;
            S_CLEAR:   state_next = S_STREAM;
            S_STREAM:  if (beat == LAST_BEAT) state_next = S_FLUSH;
            S_FLUSH:   state_next = S_CAPTURE;
            S_CAPTURE: state_next = S_HOLD;
            S_HOLD:    if (result_ready) state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    // mac_clear is decoded from the next state so it leaves a flop cleanly during CLEAR.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            beat      <= '0;
            mac_clear <= 1'b0;
            result    <= '0;
        end else begin
            state     <= state_next;
            mac_clear <= (state_next == S_CLEAR);
            if (state == S_STREAM) beat <= beat + CNT_W'(1);
            else                   beat <= '0;
            if (state == S_CAPTURE) result <= mac_out;
        end
    end

`ifdef NEURON_DRIVER_BIAS_EN
    logic signed [WIDTH-1:0] bias_hold;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                 bias_hold <= '0;
        else if (state == S_CLEAR) bias_hold <= bias;
    end
`endif

    // Buffer read runs one beat ahead of the operands it feeds; FLUSH pushes zeros.
    always_comb begin
        rd_en      = 1'b0;
        rd_addr    = '0;
        mac_enable = 1'b0;
        mac_a      = '0;
        mac_b      = '0;
        case (state)
            S_CLEAR: rd_en = 1'(RD_OFS);
            S_STREAM: begin
                mac_enable = 1'b1;
                if (read_idx < READ_LIMIT) begin
                    rd_en   = 1'b1;
                    rd_addr = ADDR_W'(read_idx);
                end
`ifdef NEURON_DRIVER_BIAS_EN
                if (beat == '0) begin
                    mac_a = bias_hold;
                    mac_b = ONE;
                end else begin
                    mac_a = act_rdata;
                    mac_b = wt_rdata;
                end
`else
                mac_a = act_rdata;
                mac_b = wt_rdata;
`endif
            end
            S_FLUSH: mac_enable = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_neuron_driver.sv
// Randomized bench for neuron_driver with behavioural buffer and MAC models;
// expected results come from a plain dot-product reference.
module tb_neuron_driver;

    localparam int WIDTH     = 8;
    localparam int VEC_LEN   = 3;
    localparam int INT_BITS  = 2;
    localparam int ADDR_W    = 2;
    localparam int FRAC_BITS = WIDTH - INT_BITS;
`ifdef NEURON_DRIVER_BIAS_EN
    localparam int BIAS_BEATS = 1;
`else
    localparam int BIAS_BEATS = 0;
`endif

    logic clk = 1'b0;
    logic reset, start, busy, rd_en, mac_clear, mac_enable, result_valid, result_ready;
    logic [ADDR_W-1:0] rd_addr;
    logic signed [WIDTH-1:0] act_rdata, wt_rdata, mac_a, mac_b, result;
    logic signed [WIDTH-1:0] mac_out = '0;
    logic signed [WIDTH-1:0] act_mem [VEC_LEN];
    logic signed [WIDTH-1:0] wt_mem  [VEC_LEN];
    int mac_acc  = 0;
    int bias_val = 0;
    int checks   = 0;
    int errors   = 0;

    always #5 clk = ~clk;

`ifdef NEURON_DRIVER_BIAS_EN
    logic signed [WIDTH-1:0] bias;
    assign bias = WIDTH'(bias_val);
`endif

    neuron_driver #(.WIDTH(WIDTH), .VEC_LEN(VEC_LEN), .INT_BITS(INT_BITS), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy),
        .rd_en(rd_en), .rd_addr(rd_addr), .act_rdata(act_rdata), .wt_rdata(wt_rdata),
        .mac_clear(mac_clear), .mac_enable(mac_enable), .mac_a(mac_a), .mac_b(mac_b),
        .mac_out(mac_out),
`ifdef NEURON_DRIVER_BIAS_EN
        .bias(bias),
`endif
        .result(result), .result_valid(result_valid), .result_ready(result_ready)
    );

    // Fixed-point rescale followed by ReLU and saturation, as the MAC applies it.
    function automatic logic signed [WIDTH-1:0] scaleClamp(input int v);
        int s;
        s = v >>> FRAC_BITS;
        if (s < 0)   return '0;
        if (s > 127) return 8'sd127;
        return WIDTH'(s);
    endfunction

    function automatic int expectedResult();
        int sum;
        sum = bias_val * (1 << FRAC_BITS);
        for (int i = 0; i < VEC_LEN; i++) sum += int'(act_mem[i]) * int'(wt_mem[i]);
        return int'(scaleClamp(sum));
    endfunction

    // Synchronous-read buffers; unread cycles return junk so stray reads are exposed.
    always @(posedge clk) begin
        if (rd_en && int'(rd_addr) < VEC_LEN) begin
            act_rdata <= act_mem[rd_addr];
            wt_rdata  <= wt_mem[rd_addr];
        end else begin
            act_rdata <= WIDTH'($urandom);
            wt_rdata  <= WIDTH'($urandom);
        end
    end

    // MAC with one-cycle output lag, cleared only through mac_clear.
    always @(posedge clk) begin
        if (mac_clear) begin
            mac_acc <= 0;
            mac_out <= '0;
        end else if (mac_enable) begin
            mac_acc <= mac_acc + int'(mac_a) * int'(mac_b);
            mac_out <= scaleClamp(mac_acc);
        end
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic loadVectors(input int a0, input int a1, input int a2,
                               input int w0, input int w1, input int w2);
        act_mem[0] = WIDTH'(a0); act_mem[1] = WIDTH'(a1); act_mem[2] = WIDTH'(a2);
        wt_mem[0]  = WIDTH'(w0); wt_mem[1]  = WIDTH'(w1); wt_mem[2]  = WIDTH'(w2);
    endtask

    task automatic loadRandom();
        for (int i = 0; i < VEC_LEN; i++) begin
            act_mem[i] = WIDTH'($urandom);
            wt_mem[i]  = WIDTH'($urandom);
        end
    endtask

    // Called at a negedge; runs one neuron evaluation and completes its handshake.
    task automatic applyStimulus(input string tag, input int hold_cycles, input bit pulse_start);
        int cyc, en_cnt, clr_cnt, first_b, exp_res, exp_first_b;
        int rd_q[$];
        bit first_seen;
        exp_res     = expectedResult();
        exp_first_b = (BIAS_BEATS != 0) ? (1 << FRAC_BITS) : int'(wt_mem[0]);
        start = 1'b1;
        result_ready = (hold_cycles == 0);
        @(negedge clk);
        start = 1'b0;
        cyc = 0; en_cnt = 0; clr_cnt = 0; first_b = 0; first_seen = 1'b0;
        while (!result_valid && cyc < 40) begin
            if (rd_en) rd_q.push_back(int'(rd_addr));
            if (mac_clear) clr_cnt++;
            if (mac_enable) begin
                en_cnt++;
                if (!first_seen) begin
                    first_b = int'(mac_b);
                    first_seen = 1'b1;
                end
            end
            @(negedge clk);
            cyc++;
        end
        checkOutput({tag, " latency"}, cyc, VEC_LEN + 3 + BIAS_BEATS);
        checkOutput({tag, " enable_cycles"}, en_cnt, VEC_LEN + 1 + BIAS_BEATS);
        checkOutput({tag, " clear_cycles"}, clr_cnt, 1);
        checkOutput({tag, " first_mac_b"}, first_b, exp_first_b);
        checkOutput({tag, " read_count"}, rd_q.size(), VEC_LEN);
        for (int i = 0; i < rd_q.size() && i < VEC_LEN; i++)
            checkOutput({tag, " read_addr"}, rd_q[i], i);
        checkOutput({tag, " result"}, int'(result), exp_res);
        for (int k = 0; k < hold_cycles; k++) begin
            checkOutput({tag, " hold_valid"}, int'(result_valid), 1);
            checkOutput({tag, " hold_result"}, int'(result), exp_res);
            start = pulse_start && (k == 2);
            @(negedge clk);
        end
        start = 1'b0;
        result_ready = 1'b1;
        @(negedge clk);
        checkOutput({tag, " busy_after_handshake"}, int'(busy), 0);
        checkOutput({tag, " valid_after_handshake"}, int'(result_valid), 0);
        result_ready = 1'b0;
    endtask

    task automatic checkAllReset(input string tag);
        checkOutput({tag, " busy"}, int'(busy), 0);
        checkOutput({tag, " rd_en"}, int'(rd_en), 0);
        checkOutput({tag, " rd_addr"}, int'(rd_addr), 0);
        checkOutput({tag, " mac_clear"}, int'(mac_clear), 0);
        checkOutput({tag, " mac_enable"}, int'(mac_enable), 0);
        checkOutput({tag, " mac_a"}, int'(mac_a), 0);
        checkOutput({tag, " mac_b"}, int'(mac_b), 0);
        checkOutput({tag, " result"}, int'(result), 0);
        checkOutput({tag, " result_valid"}, int'(result_valid), 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1; start = 1'b0; result_ready = 1'b0;
        loadVectors(0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        checkAllReset("reset");
        reset = 1'b0;
        @(negedge clk);

        loadVectors(64, 32, -64, 64, 64, 32);
        applyStimulus("basic", 0, 1'b0);

        loadVectors(-64, -64, 0, 64, 64, 0);
        applyStimulus("negative", 0, 1'b0);

        loadVectors(127, 127, 127, 127, 127, 127);
        applyStimulus("saturate", 0, 1'b0);

        // Start pulsed during HOLD must not queue a second run.
        loadVectors(64, 32, -64, 64, 64, 32);
        applyStimulus("backpressure", 5, 1'b1);
        @(negedge clk);
        checkOutput("no_queued_start", int'(busy), 0);
        loadRandom();
        applyStimulus("earliest_restart", 0, 1'b0);

        loadVectors(127, 127, 127, 127, 127, 127);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("abort enable_in_stream", int'(mac_enable), 1);
        reset = 1'b1;
        #1;
        checkAllReset("abort");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        loadVectors(64, 32, -64, 64, 64, 32);
        applyStimulus("after_abort", 0, 1'b0);

`ifdef NEURON_DRIVER_BIAS_EN
        bias_val = -32;
        applyStimulus("bias", 0, 1'b0);
        bias_val = 0;
`endif

        for (int r = 0; r < 20; r++) begin
            loadRandom();
            repeat ($urandom_range(0, 2)) @(negedge clk);
            applyStimulus("random", $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
